// File: rtl/music_key_recorder_player_pkg.sv
`default_nettype none
// ============================================================================
// Module   : music_box_pkg
// Purpose  : Shared definitions for the music box blocks: state codes driven
//            by MusicBoxStateController, the released key pattern and the
//            stored key-event record layout.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package music_box_pkg;

  typedef logic [4:0] state_code_t;

  localparam state_code_t STATE_IDLE     = 5'd0;
  localparam state_code_t STATE_RECORD   = 5'd3;
  localparam state_code_t STATE_PLAYBACK = 5'd4;

  // Keys are active-low: all ones means nothing pressed.
  localparam logic [5:0] KEYS_RELEASED = 6'h3F;

  // Default duration field width of a stored event.
  localparam int EVT_DUR_W = 10;

  typedef struct packed {
    logic [5:0]           keys;
    logic [EVT_DUR_W-1:0] dur;
  } key_event_t;

endpackage
`default_nettype wire

// File: rtl/music_key_recorder_player_if.sv
`default_nettype none
// ============================================================================
// Module   : music_key_recorder_player_if
// Purpose  : Bundles the state/key inputs and the replay/status outputs of the
//            key recorder-player.
// Ports    : currentState, input_MusicKey        (towards the recorder)
//            output_MusicKey, isPlaying, playDone,
//            recordFull, eventCount               (from the recorder)
//            modport slave  - recorder side
//            modport master - environment side
// Revision : 1.0 - initial release
// ============================================================================
interface music_key_recorder_player_if
  import music_box_pkg::*;
#(
  parameter int DEPTH = 64
) ();

  localparam int CNT_W = $clog2(DEPTH) + 1;

  state_code_t      currentState;
  logic [5:0]       input_MusicKey;
  logic [5:0]       output_MusicKey;
  logic             isPlaying;
  logic             playDone;
  logic             recordFull;
  logic [CNT_W-1:0] eventCount;

  modport slave (
    input  currentState, input_MusicKey,
    output output_MusicKey, isPlaying, playDone, recordFull, eventCount
  );

  modport master (
    output currentState, input_MusicKey,
    input  output_MusicKey, isPlaying, playDone, recordFull, eventCount
  );

endinterface
`default_nettype wire

// File: rtl/music_key_recorder_player_ram.sv
`default_nettype none
// ============================================================================
// Module   : key_event_ram
// Purpose  : Simple dual-port event store. One write port, one synchronous
//            read port with one cycle of latency; no reset so it maps onto
//            block RAM.
// Ports    : clk    - clock
//            we     - write enable
//            waddr  - write address
//            wdata  - write data
//            raddr  - read address (sampled on the rising edge)
//            rdata  - read data, valid one cycle after raddr
// Revision : 1.0 - initial release
// ============================================================================
module key_event_ram #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 16
) (
  input  wire logic                     clk,
  input  wire logic                     we,
  input  wire logic [$clog2(DEPTH)-1:0] waddr,
  input  wire logic [WIDTH-1:0]         wdata,
  input  wire logic [$clog2(DEPTH)-1:0] raddr,
  output logic      [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule
`default_nettype wire

// File: rtl/music_key_recorder_player.sv
`default_nettype none
// ============================================================================
// Module   : music_key_recorder_player
// Purpose  : Records the six active-low music keys as run-length encoded
//            events {keys, dur} while in the record state and replays them as
//            an active-low key vector while in the playback state.
// Ports    : CLK_1Khz - 1 kHz tick clock, rising edge
//            reset_n  - asynchronous active-low reset
//            bus      - slave modport: currentState, input_MusicKey in;
//                       output_MusicKey, isPlaying, playDone, recordFull,
//                       eventCount out
// Revision : 1.0 - initial release
// ============================================================================
module music_key_recorder_player
  import music_box_pkg::*;
#(
  parameter int          DEPTH      = 64,
  parameter int          DUR_W      = EVT_DUR_W,
  parameter state_code_t REC_STATE  = STATE_RECORD,
  parameter state_code_t PLAY_STATE = STATE_PLAYBACK
) (
  input wire logic CLK_1Khz,
  input wire logic reset_n,
  music_key_recorder_player_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 6 + DUR_W;
  localparam logic [DUR_W-1:0] MAX_DUR = '1;

  localparam logic [1:0] PS_IDLE  = 2'd0;
  localparam logic [1:0] PS_FETCH = 2'd1;
  localparam logic [1:0] PS_RUN   = 2'd2;
  localparam logic [1:0] PS_DONE  = 2'd3;

  state_code_t      state_q;

  // Recorder
  logic [5:0]       cur_keys;
  logic [DUR_W-1:0] dur;
  logic [CW-1:0]    wr_ptr;
  logic             record_full;
  logic [CW-1:0]    event_count;

  // Player
  logic [1:0]       play_state;
  logic [5:0]       play_keys;
  logic [DUR_W-1:0] remaining;
  logic [CW-1:0]    rd_ptr;
  logic             start_pending;

  // RAM
  logic             ram_we;
  logic [AW-1:0]    ram_waddr;
  logic [EW-1:0]    ram_wdata;
  logic [AW-1:0]    ram_raddr;
  logic [EW-1:0]    ram_rdata;

  logic rec_entry, rec_exit, rec_active, rec_split;
  logic play_entry, in_play, rd_last, advance;

  assign rec_entry  = (bus.currentState == REC_STATE) && (state_q != REC_STATE);
  assign rec_exit   = (state_q == REC_STATE) && (bus.currentState != REC_STATE);
  assign rec_active = (state_q == REC_STATE) && (bus.currentState == REC_STATE);
  assign play_entry = (bus.currentState == PLAY_STATE) && (state_q != PLAY_STATE);
  assign in_play    = (bus.currentState == PLAY_STATE);

  // A change of keys or a saturated duration closes the current entry.
  assign rec_split  = (bus.input_MusicKey != cur_keys) || (dur == MAX_DUR);

  assign ram_we    = !record_full && ((rec_active && rec_split) || rec_exit);
  assign ram_waddr = wr_ptr[AW-1:0];
  assign ram_wdata = {cur_keys, dur};

  assign rd_last = (rd_ptr == event_count);
  assign advance = (play_state == PS_RUN) && (remaining == DUR_W'(1)) && !rd_last;

  // Read address runs one entry ahead so the next event is already on rdata
  // when the current one expires; this gives back-to-back events with no gap.
  always_comb begin
    ram_raddr = '0;
    case (play_state)
      PS_FETCH: ram_raddr = AW'(1);
      PS_RUN:   ram_raddr = advance ? (rd_ptr[AW-1:0] + AW'(1)) : rd_ptr[AW-1:0];
      default:  ram_raddr = '0;
    endcase
  end

  key_event_ram #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_ram (
    .clk   (CLK_1Khz),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  // Recorder datapath
  always_ff @(posedge CLK_1Khz or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= STATE_IDLE;
      cur_keys    <= KEYS_RELEASED;
      dur         <= '0;
      wr_ptr      <= '0;
      record_full <= 1'b0;
      event_count <= '0;
    end else begin
      state_q <= bus.currentState;
      if (rec_entry) begin
        wr_ptr      <= '0;
        event_count <= '0;
        record_full <= 1'b0;
        cur_keys    <= bus.input_MusicKey;
        dur         <= DUR_W'(1);
      end else if (rec_active) begin
        if (!record_full) begin
          if (rec_split) begin
            wr_ptr   <= wr_ptr + CW'(1);
            cur_keys <= bus.input_MusicKey;
            dur      <= DUR_W'(1);
            if (wr_ptr == CW'(DEPTH - 1)) begin
              record_full <= 1'b1;
            end
          end else begin
            dur <= dur + DUR_W'(1);
          end
        end
      end else if (rec_exit) begin
        // When full the last run is dropped, so no flush entry is counted.
        event_count <= record_full ? wr_ptr : (wr_ptr + CW'(1));
      end
    end
  end

  // Player FSM
  always_ff @(posedge CLK_1Khz or negedge reset_n) begin
    if (!reset_n) begin
      play_state    <= PS_IDLE;
      play_keys     <= KEYS_RELEASED;
      remaining     <= '0;
      rd_ptr        <= '0;
      start_pending <= 1'b0;
    end else begin
      // Going straight from REC to PLAY: the count settles on the transition
      // edge, so playback is started one edge later.
      start_pending <= play_entry && (state_q == REC_STATE);
      if (!in_play) begin
        play_state <= PS_IDLE;
      end else begin
        case (play_state)
          PS_IDLE: begin
            if ((play_entry && (state_q != REC_STATE)) || start_pending) begin
              play_state <= (event_count == '0) ? PS_DONE : PS_FETCH;
            end
          end
          PS_FETCH: begin
            play_keys  <= ram_rdata[EW-1:DUR_W];
            remaining  <= ram_rdata[DUR_W-1:0];
            rd_ptr     <= CW'(1);
            play_state <= PS_RUN;
          end
          PS_RUN: begin
            if (remaining > DUR_W'(1)) begin
              remaining <= remaining - DUR_W'(1);
            end else if (!rd_last) begin
              play_keys <= ram_rdata[EW-1:DUR_W];
              remaining <= ram_rdata[DUR_W-1:0];
              rd_ptr    <= rd_ptr + CW'(1);
            end else begin
              play_state <= PS_DONE;
            end
          end
          default: begin
            play_state <= PS_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.output_MusicKey = (play_state == PS_RUN) ? play_keys : KEYS_RELEASED;
  assign bus.isPlaying       = (play_state == PS_RUN);
  assign bus.playDone        = (play_state == PS_DONE);
  assign bus.recordFull      = record_full;
  assign bus.eventCount      = event_count;

endmodule
`default_nettype wire
